reduce_pipe: RTL

- Parametrised, pipelined successor to the single-register wide-bus OR reducer.
- Reduces a WIDTH-bit input bus to one bit using a run-time selectable operator (OR, AND, XOR, NOR) through a radix-RADIX tree, with one register stage per tree level.
- Provides ready/valid handshakes on input and output, and a saturating count of results equal to 1.
- Sits between a wide datapath producer and control logic that consumes flag bits.

---
 rtl/reduce_pipe_if.sv | 24 ++
 rtl/reduce_pipe.sv | 88 ++++++++
 2 files changed

// File: rtl/reduce_pipe_if.sv
// reduce_pipe_if: producer/consumer handshake bundle for the pipelined bus reducer.
interface reduce_pipe_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_bits;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic [1:0]       out_mode;
  logic             clear_count;
  logic [CNT_W-1:0] ones_count;
  modport master (
    output in_valid, in_bits, in_mode, out_ready, clear_count,
    input  in_ready, out_valid, out_bit, out_mode, ones_count
  );
  modport slave (
    input  in_valid, in_bits, in_mode, out_ready, clear_count,
    output in_ready, out_valid, out_bit, out_mode, ones_count
  );
endinterface

// File: rtl/reduce_pipe.sv
// reduce_pipe: radix-RADIX OR/AND/XOR/NOR reduction tree, one register per level, global stall.
module reduce_pipe #(
  parameter int WIDTH = 64,
  parameter int RADIX = 4,
  parameter int CNT_W = 16
) (
  input logic        clock,
  input logic        reset,
  reduce_pipe_if.slave io
);
  function automatic int lw(int k);
    int x;
    x = WIDTH;
    for (int n = 0; n < k; n++) x = (x + RADIX - 1) / RADIX;
    return x;
  endfunction
  function automatic int calc_stages();
    int x;
    int s;
    x = WIDTH;
    s = 0;
    while (x > 1) begin
      x = (x + RADIX - 1) / RADIX;
      s++;
    end
    return s < 1 ? 1 : s;
  endfunction
  localparam int STAGES = calc_stages();
  logic advance;
  assign advance     = !io.out_valid | io.out_ready;
  assign io.in_ready = advance;
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int IW = lw(k);
    localparam int OW = lw(k + 1);
    logic [IW-1:0] src;
    logic [1:0]    src_mode;
    logic          src_vld;
    logic [OW-1:0] nxt;
    logic [OW-1:0] d_q;
    logic [1:0]    m_q;
    logic          v_q;
    if (k == 0) begin : first
      assign src      = io.in_bits;
      assign src_mode = io.in_mode;
      assign src_vld  = io.in_valid;
    end else begin : chain
      assign src      = stg[k-1].d_q;
      assign src_mode = stg[k-1].m_q;
      assign src_vld  = stg[k-1].v_q;
    end
    for (genvar j = 0; j < OW; j++) begin : node
      logic [RADIX-1:0] grp;
      // Missing inputs of a partial group take the identity of the base operator.
      for (genvar i = 0; i < RADIX; i++) begin : pad
        if (j * RADIX + i < IW) begin : real_bit
          assign grp[i] = src[j*RADIX+i];
        end else begin : ident
          assign grp[i] = src_mode == 2'b01;
        end
      end
      // NOR is carried as OR through the tree and inverted only on the last level.
      assign nxt[j] = (src_mode == 2'b01 ? &grp : src_mode == 2'b10 ? ^grp : |grp)
                      ^ (k == STAGES - 1 && src_mode == 2'b11);
    end
    always_ff @(posedge clock) begin
      if (reset) begin
        v_q <= 1'b0;
        d_q <= '0;
        m_q <= 2'b00;
      end else if (advance) begin
        v_q <= src_vld;
        if (src_vld) begin
          d_q <= nxt;
          m_q <= src_mode;
        end
      end
    end
  end
  assign io.out_valid = stg[STAGES-1].v_q;
  assign io.out_bit   = stg[STAGES-1].d_q[0];
  assign io.out_mode  = stg[STAGES-1].m_q;
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clock) begin
    if (reset || io.clear_count) cnt_q <= '0;
    else if (io.out_valid && io.out_ready && io.out_bit && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end
  assign io.ones_count = cnt_q;
endmodule
